// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: op codes, opcode/funct
// constants, FSM states and small word-building helpers.
package inst_encoder_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_NOR  = 5'd5,  OP_SLT  = 5'd6,  OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,  OP_JR   = 5'd9,  OP_JALR = 5'd10, OP_ADDI = 5'd11,
    OP_ANDI = 5'd12, OP_SLTI = 5'd13, OP_BEQ  = 5'd14, OP_BNE  = 5'd15,
    OP_LW   = 5'd16, OP_LH   = 5'd17, OP_SW   = 5'd18, OP_SH   = 5'd19,
    OP_J    = 5'd20, OP_JAL  = 5'd21
  } op_e;

  localparam logic [4:0] OP_LIMIT = 5'd22;

  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
                         FN_SLT = 6'h2A, FN_SLL = 6'h00, FN_SRL = 6'h02,
                         FN_JR  = 6'h08, FN_JALR = 6'h09;

  localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ANDI = 6'h0C, OPC_SLTI = 6'h0A,
                         OPC_BEQ  = 6'h04, OPC_BNE  = 6'h05, OPC_LW   = 6'h23,
                         OPC_LH   = 6'h21, OPC_SW   = 6'h2B, OPC_SH   = 6'h29,
                         OPC_J    = 6'h02, OPC_JAL  = 6'h03;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] sh,
                                         logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs,
                                         logic [4:0] rt, logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Descriptor input, instruction-memory write port and session status of the encoder.
interface inst_encoder_if;
  logic        start;
  logic [9:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        im_busy;
  logic [10:0] count;
  logic        done;
  logic        err;
  logic        wrap;

  modport slave (
    input  start, base_addr, in_valid, op, rs, rt, rd, shamt, imm, target, last, im_busy,
    output in_ready, im_we, im_addr, im_wdata, count, done, err, wrap
  );

  modport master (
    output start, base_addr, in_valid, op, rs, rt, rd, shamt, imm, target, last, im_busy,
    input  in_ready, im_we, im_addr, im_wdata, count, done, err, wrap
  );
endinterface

// File: rtl/inst_field_pack.sv
// Combinational mapping of an op and its fields to a 32-bit MIPS word plus a legal flag.
module inst_field_pack
  import inst_encoder_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = 32'h0;
    legal_o = (op_i < OP_LIMIT);
    case (op_i)
      OP_ADD:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
      OP_SUB:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
      OP_AND:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
      OP_OR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
      OP_XOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
      OP_NOR:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
      OP_SLT:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
      // Shifts take their amount from shamt and ignore rs.
      OP_SLL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
      OP_SRL:  word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
      OP_JR:   word_o = r_word(rs_i, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_JALR: word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_JALR);
      OP_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i);
      OP_ANDI: word_o = i_word(OPC_ANDI, rs_i, rt_i, imm_i);
      OP_SLTI: word_o = i_word(OPC_SLTI, rs_i, rt_i, imm_i);
      OP_BEQ:  word_o = i_word(OPC_BEQ, rs_i, rt_i, imm_i);
      OP_BNE:  word_o = i_word(OPC_BNE, rs_i, rt_i, imm_i);
      OP_LW:   word_o = i_word(OPC_LW, rs_i, rt_i, imm_i);
      OP_LH:   word_o = i_word(OPC_LH, rs_i, rt_i, imm_i);
      OP_SW:   word_o = i_word(OPC_SW, rs_i, rt_i, imm_i);
      OP_SH:   word_o = i_word(OPC_SH, rs_i, rt_i, imm_i);
      OP_J:    word_o = {OPC_J, target_i};
      OP_JAL:  word_o = {OPC_JAL, target_i};
      default: word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Session FSM: accepts instruction descriptors, encodes them and writes the words
// to consecutive instruction-memory addresses.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  inst_encoder_if.slave  bus
);

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [10:0] count_q, count_d;
  logic        err_q, err_d;
  logic        wrap_q, wrap_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [31:0] packed_word;
  logic        packed_legal;
  logic        in_ready, im_we, done;

  inst_field_pack u_pack (
    .op_i     (bus.op),
    .rs_i     (bus.rs),
    .rt_i     (bus.rt),
    .rd_i     (bus.rd),
    .shamt_i  (bus.shamt),
    .imm_i    (bus.imm),
    .target_i (bus.target),
    .word_o   (packed_word),
    .legal_o  (packed_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 10'd0;
      count_q <= 11'd0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      word_q  <= 32'h0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      word_q  <= word_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    wrap_d   = wrap_q;
    word_d   = word_q;
    last_d   = last_q;
    in_ready = 1'b0;
    im_we    = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ACCEPT;
          addr_d  = bus.base_addr;
          count_d = 11'd0;
          err_d   = 1'b0;
          wrap_d  = 1'b0;
        end
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          if (packed_legal) begin
            word_d  = packed_word;
            last_d  = bus.last;
            state_d = ST_WRITE;
          end else begin
            // Illegal descriptors are consumed without a write.
            err_d = 1'b1;
            if (bus.last) state_d = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        im_we = 1'b1;
        if (!bus.im_busy) begin
          addr_d  = addr_q + 10'd1;
          count_d = count_q + 11'd1;
          if (addr_q == 10'h3FF) wrap_d = 1'b1;
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.im_we    = im_we;
  assign bus.done     = done;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = word_q;
  assign bus.count    = count_q;
  assign bus.err      = err_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: single-op encoding table plus multi-cycle sessions.
module tb_inst_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_encoder_if bus ();

  inst_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [14];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          done_cnt = 0;
  logic [9:0]  wa_q [$];
  logic [31:0] wd_q [$];

  // Record every completed memory write and every done pulse.
  always @(negedge clk) begin
    if (!rst && bus.im_we && !bus.im_busy) begin
      wa_q.push_back(bus.im_addr);
      wd_q.push_back(bus.im_wdata);
      $display("write addr=%0d data=%h", bus.im_addr, bus.im_wdata);
    end
    if (!rst && bus.done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [9:0] base);
    wa_q.delete();
    wd_q.delete();
    bus.start     = 1'b1;
    bus.base_addr = base;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic lst);
    int n = 0;
    bus.op = op; bus.rs = rs; bus.rt = rt; bus.rd = rd; bus.shamt = sh;
    bus.imm = imm; bus.target = tgt; bus.last = lst; bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {31'd0, bus.done}, 32'd1);
    tick();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{5'd0,  5'd1,  5'd2, 5'd3,  5'd0,  16'h0000, 26'h0, 32'h00221820}; // add
    vecs[1]  = '{5'd1,  5'd4,  5'd5, 5'd6,  5'd3,  16'h0000, 26'h0, 32'h00853022}; // sub, shamt dropped
    vecs[2]  = '{5'd7,  5'd7,  5'd1, 5'd2,  5'd4,  16'h0000, 26'h0, 32'h00011100}; // sll, rs forced 0
    vecs[3]  = '{5'd8,  5'd0,  5'd3, 5'd4,  5'd31, 16'h0000, 26'h0, 32'h000327C2}; // srl
    vecs[4]  = '{5'd9,  5'd31, 5'd5, 5'd6,  5'd0,  16'h0000, 26'h0, 32'h03E00008}; // jr, rt/rd forced 0
    vecs[5]  = '{5'd5,  5'd1,  5'd1, 5'd1,  5'd0,  16'h0000, 26'h0, 32'h00210827}; // nor
    vecs[6]  = '{5'd6,  5'd2,  5'd3, 5'd4,  5'd0,  16'h0000, 26'h0, 32'h0043202A}; // slt
    vecs[7]  = '{5'd10, 5'd5,  5'd0, 5'd31, 5'd0,  16'h0000, 26'h0, 32'h00A0F809}; // jalr
    vecs[8]  = '{5'd12, 5'd3,  5'd4, 5'd0,  5'd0,  16'h00FF, 26'h0, 32'h306400FF}; // andi
    vecs[9]  = '{5'd19, 5'd1,  5'd2, 5'd0,  5'd0,  16'h8000, 26'h0, 32'hA4228000}; // sh
    vecs[10] = '{5'd21, 5'd0,  5'd0, 5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF}; // jal
    vecs[11] = '{5'd15, 5'd0,  5'd0, 5'd0,  5'd0,  16'h1234, 26'h0, 32'h14001234}; // bne
    vecs[12] = '{5'd4,  5'd2,  5'd3, 5'd4,  5'd0,  16'h0000, 26'h0, 32'h00432026}; // xor
    vecs[13] = '{5'd17, 5'd1,  5'd2, 5'd0,  5'd0,  16'h0004, 26'h0, 32'h84220004}; // lh

    bus.start = 0; bus.base_addr = 0; bus.in_valid = 0; bus.op = 0; bus.rs = 0;
    bus.rt = 0; bus.rd = 0; bus.shamt = 0; bus.imm = 0; bus.target = 0;
    bus.last = 0; bus.im_busy = 0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_im_we", {31'd0, bus.im_we}, 32'd0);
    chk("rst_count", {21'd0, bus.count}, 32'd0);
    chk("rst_im_addr", {22'd0, bus.im_addr}, 32'd0);
    chk("rst_flags", {29'd0, bus.done, bus.err, bus.wrap}, 32'd0);
    tick();

    // Table: each op as a one-descriptor session.
    for (int i = 0; i < 14; i++) begin
      start_session(10'(i * 3));
      send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
           vecs[i].imm, vecs[i].tgt, 1'b1);
      wait_done();
      chk($sformatf("v%0d_nwrites", i), wa_q.size(), 32'd1);
      if (wa_q.size() == 1) begin
        chk($sformatf("v%0d_addr", i), {22'd0, wa_q[0]}, 32'(i * 3));
        chk($sformatf("v%0d_word", i), wd_q[0], vecs[i].exp);
      end
      chk($sformatf("v%0d_count", i), {21'd0, bus.count}, 32'd1);
      chk($sformatf("v%0d_err", i), {31'd0, bus.err}, 32'd0);
    end

    // Four-instruction program, done must pulse once.
    begin
      logic [31:0] prog [4];
      int d0;
      prog[0] = 32'h20080005; prog[1] = 32'h8FA90004;
      prog[2] = 32'h1022FFFF; prog[3] = 32'h08000100;
      d0 = done_cnt;
      start_session(10'd100);
      send(5'd11, 5'd0,  5'd8, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b0);
      send(5'd16, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b0);
      send(5'd14, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
      send(5'd20, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000100, 1'b1);
      wait_done();
      chk("prog_nwrites", wa_q.size(), 32'd4);
      for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
        chk($sformatf("prog_addr%0d", k), {22'd0, wa_q[k]}, 32'(100 + k));
        chk($sformatf("prog_word%0d", k), wd_q[k], prog[k]);
      end
      chk("prog_count", {21'd0, bus.count}, 32'd4);
      chk("prog_done_pulses", done_cnt - d0, 32'd1);
    end

    // Write stalled by im_busy for three cycles.
    start_session(10'd200);
    bus.im_busy = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) bus.im_busy = 1'b0;
      @(negedge clk);
      chk($sformatf("busy_we%0d", k), {31'd0, bus.im_we}, 32'd1);
      chk($sformatf("busy_addr%0d", k), {22'd0, bus.im_addr}, 32'd200);
      chk($sformatf("busy_data%0d", k), bus.im_wdata, 32'h00221820);
      tick();
    end
    wait_done();
    chk("busy_nwrites", wa_q.size(), 32'd1);
    chk("busy_count", {21'd0, bus.count}, 32'd1);

    // Address wrap from 1023 to 0.
    start_session(10'd1023);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000100, 1'b1);
    wait_done();
    chk("wrap_nwrites", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("wrap_addr0", {22'd0, wa_q[0]}, 32'd1023);
      chk("wrap_addr1", {22'd0, wa_q[1]}, 32'd0);
    end
    chk("wrap_flag", {31'd0, bus.wrap}, 32'd1);
    chk("wrap_count", {21'd0, bus.count}, 32'd2);

    // Illegal op between two legal ones.
    start_session(10'd300);
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    send(5'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1);
    wait_done();
    chk("ill_nwrites", wa_q.size(), 32'd2);
    if (wa_q.size() == 2) begin
      chk("ill_addr1", {22'd0, wa_q[1]}, 32'd301);
      chk("ill_word1", wd_q[1], 32'h00853022);
    end
    chk("ill_err", {31'd0, bus.err}, 32'd1);
    chk("ill_count", {21'd0, bus.count}, 32'd2);
    chk("ill_wrap", {31'd0, bus.wrap}, 32'd0);

    // Reset while a write is stalled.
    start_session(10'd400);
    chk("restart_err_cleared", {31'd0, bus.err}, 32'd0);
    bus.im_busy = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
    @(negedge clk);
    chk("rstw_we_before", {31'd0, bus.im_we}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.im_busy = 1'b0;
    @(negedge clk);
    chk("rstw_im_we", {31'd0, bus.im_we}, 32'd0);
    chk("rstw_count", {21'd0, bus.count}, 32'd0);
    chk("rstw_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rstw_im_addr", {22'd0, bus.im_addr}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstw_nwrites", wa_q.size(), 32'd0);
    chk("rstw_idle_we", {31'd0, bus.im_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
